// File: rtl/instr_sequencer_if.sv
// Handshake and control bundle between the instruction source and the sequencer.
// master drives run/instr; slave (the sequencer) drives the datapath controls.
interface instr_sequencer_if #(
  parameter int WIDTH = 16,
  parameter int REG_N = 8
);
  localparam int AW = $clog2(REG_N);

  logic             run;
  logic [WIDTH-1:0] instr;
  logic             busy;
  logic             done;
  logic             illegal;
  logic [AW-1:0]    wr_addr;
  logic             wr_en;
  logic [AW-1:0]    rd_sel;
  logic [1:0]       bus_src;
  logic             a_load;
  logic             g_load;
  logic             alu_sub;

  modport master (
    output run, instr,
    input  busy, done, illegal,
    input  wr_addr, wr_en, rd_sel,
    input  bus_src, a_load, g_load, alu_sub
  );

  modport slave (
    input  run, instr,
    output busy, done, illegal,
    output wr_addr, wr_en, rd_sel,
    output bus_src, a_load, g_load, alu_sub
  );
endinterface

// File: rtl/instr_sequencer.sv
// Multi-cycle control FSM: latches one instruction, then sequences
// register reads/writes, A/G loads and bus source over 1-3 cycles.
module instr_sequencer #(
  parameter int WIDTH = 16,
  parameter int REG_N = 8
) (
  input  logic               clk,
  input  logic               reset,
  instr_sequencer_if.slave   bus
);
  localparam int AW = $clog2(REG_N);
  localparam int RW = WIDTH - 4 - 2 * AW;

  typedef enum logic [1:0] {
    IDLE,
    T1,
    T2,
    T3
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] ir_q, ir_d;

  logic [3:0]    op;
  logic [AW-1:0] rx;
  logic [AW-1:0] ry;
  logic          is_mv;
  logic          is_mvi;
  logic          is_alu;

  assign op     = ir_q[WIDTH-1 -: 4];
  assign rx     = ir_q[WIDTH-5 -: AW];
  assign ry     = ir_q[WIDTH-5-AW -: AW];
  assign is_mv  = (op == 4'd0);
  assign is_mvi = (op == 4'd1);
  assign is_alu = (op == 4'd2) || (op == 4'd3);

  generate
    if (RW > 0) begin : g_rest
      logic [RW-1:0] unused_rest;
      assign unused_rest = ir_q[RW-1:0];
    end
  endgenerate

  always_comb begin
    state_d = state_q;
    ir_d    = ir_q;
    unique case (state_q)
      IDLE: begin
        if (bus.run) begin
          ir_d    = bus.instr;
          state_d = T1;
        end
      end
      T1:      state_d = is_alu ? T2 : IDLE;
      T2:      state_d = T3;
      T3:      state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
    end
  end

  // Outputs decode state+IR directly; everything idles at 0.
  always_comb begin
    bus.busy    = (state_q != IDLE);
    bus.done    = 1'b0;
    bus.illegal = 1'b0;
    bus.wr_addr = '0;
    bus.wr_en   = 1'b0;
    bus.rd_sel  = '0;
    bus.bus_src = 2'd0;
    bus.a_load  = 1'b0;
    bus.g_load  = 1'b0;
    bus.alu_sub = 1'b0;
    unique case (state_q)
      T1: begin
        unique case (1'b1)
          is_mv: begin
            bus.rd_sel  = ry;
            bus.wr_addr = rx;
            bus.wr_en   = 1'b1;
            bus.done    = 1'b1;
          end
          is_mvi: begin
            bus.bus_src = 2'd1;
            bus.wr_addr = rx;
            bus.wr_en   = 1'b1;
            bus.done    = 1'b1;
          end
          is_alu: begin
            bus.rd_sel = rx;
            bus.a_load = 1'b1;
          end
          default: begin
            bus.done    = 1'b1;
            bus.illegal = 1'b1;
          end
        endcase
      end
      T2: begin
        bus.rd_sel  = ry;
        bus.g_load  = 1'b1;
        bus.alu_sub = (op == 4'd3);
      end
      T3: begin
        bus.bus_src = 2'd2;
        bus.wr_addr = rx;
        bus.wr_en   = 1'b1;
        bus.done    = 1'b1;
      end
      default: ;
    endcase
  end
endmodule
